// File: rtl/cdc_handshake_tx.sv
// Source half of a toggle req/ack CDC link; optional ack timeout flag via CDC_HANDSHAKE_TX_TIMEOUT_EN.
// Latency: word on owv_xdata/ow_xreq one edge after accept; ow_done p_SYNC_DEPTH+1 edges after accept with looped ack.
// Backpressure: ow_ready low from accept until the synchronized ack matches ow_xreq; iw_valid ignored meanwhile.
module cdc_handshake_tx #(
    parameter int p_WIDTH      = 8,
    parameter int p_SYNC_DEPTH = 2,
    parameter int p_TIMEOUT    = 1023
) (
    input  logic               iw_clk,
    input  logic               iw_rst,
    input  logic [p_WIDTH-1:0] iwv_data,
    input  logic               iw_valid,
    output logic               ow_ready,
    output logic [p_WIDTH-1:0] owv_xdata,
    output logic               ow_xreq,
    input  logic               iw_xack,
    output logic               ow_done,
    output logic               ow_timeout
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_d;
    logic                   accept;
    logic                   complete;
    logic [p_SYNC_DEPTH-1:0] ack_sync;
    logic                   ack_s;
    logic [p_WIDTH-1:0]     xdata_q;
    logic                   xreq_q;
    logic                   done_q;

    generate
        if (p_SYNC_DEPTH < 2 || p_TIMEOUT < 1) begin : g_bad_param
            $error("cdc_handshake_tx: p_SYNC_DEPTH must be >= 2 and p_TIMEOUT >= 1");
        end
    endgenerate

    // Ack synchronizer; the async input only ever reaches stage 0.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[p_SYNC_DEPTH-2:0], iw_xack};
        end
    end

    assign ack_s = ack_sync[p_SYNC_DEPTH-1];

    always_comb begin
        state_d  = state;
        accept   = 1'b0;
        complete = 1'b0;
        case (state)
            S_IDLE: begin
                if (iw_valid) begin
                    accept  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ack_s == xreq_q) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state   <= S_IDLE;
            xdata_q <= '0;
            xreq_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_d;
            done_q <= complete;
            if (accept) begin
                xdata_q <= iwv_data;
                xreq_q  <= ~xreq_q;
            end
        end
    end

    assign ow_ready  = (state == S_IDLE);
    assign owv_xdata = xdata_q;
    assign ow_xreq   = xreq_q;
    assign ow_done   = done_q;

`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
    localparam int CW = $clog2(p_TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;
    logic          timeout_q;

    // Flag only; the transfer keeps waiting and completes normally if ack arrives.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT && wait_cnt != CW'(p_TIMEOUT)) begin
            wait_cnt <= wait_cnt + CW'(1);
            if (wait_cnt == CW'(p_TIMEOUT - 1)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign ow_timeout = timeout_q;
`else
    assign ow_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: loopback vector table plus delayed-ack, timeout and async-reset sequences.
module tb_cdc_handshake_tx;

    localparam int W = 8;
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif

    logic         iw_clk = 1'b0;
    logic         iw_rst = 1'b1;
    logic [W-1:0] iwv_data = '0;
    logic         iw_valid = 1'b0;
    logic         ow_ready;
    logic [W-1:0] owv_xdata;
    logic         ow_xreq;
    logic         iw_xack;
    logic         ow_done;
    logic         ow_timeout;

    logic loop = 1'b1;
    logic xack_man = 1'b0;
    assign iw_xack = loop ? ow_xreq : xack_man;

    int n_vec = 0;
    int n_err = 0;

    cdc_handshake_tx #(
        .p_WIDTH     (W),
        .p_SYNC_DEPTH(2),
        .p_TIMEOUT   (16)
    ) dut (
        .iw_clk    (iw_clk),
        .iw_rst    (iw_rst),
        .iwv_data  (iwv_data),
        .iw_valid  (iw_valid),
        .ow_ready  (ow_ready),
        .owv_xdata (owv_xdata),
        .ow_xreq   (ow_xreq),
        .iw_xack   (iw_xack),
        .ow_done   (ow_done),
        .ow_timeout(ow_timeout)
    );

    always #5 iw_clk = ~iw_clk;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic [W-1:0] x;
        logic         q;
        logic         dn;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [W-1:0] d, input logic r,
                       input logic [W-1:0] x, input logic q, input logic dn);
        vec_t e;
        e.v = v; e.d = d; e.r = r; e.x = x; e.q = q; e.dn = dn;
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iw_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // back-to-back 01,02,03 with valid held
        add(1, 8'h01, 0, 8'h01, 1, 0);
        add(1, 8'h02, 0, 8'h01, 1, 0);
        add(1, 8'h02, 0, 8'h01, 1, 0);
        add(1, 8'h02, 1, 8'h01, 1, 1);
        add(1, 8'h02, 0, 8'h02, 0, 0);
        add(1, 8'h03, 0, 8'h02, 0, 0);
        add(1, 8'h03, 0, 8'h02, 0, 0);
        add(1, 8'h03, 1, 8'h02, 0, 1);
        add(1, 8'h03, 0, 8'h03, 1, 0);
        add(0, 8'h00, 0, 8'h03, 1, 0);
        add(0, 8'h00, 0, 8'h03, 1, 0);
        add(0, 8'h00, 1, 8'h03, 1, 1);
        add(0, 8'h00, 1, 8'h03, 1, 0);
        // single 0xA5
        add(1, 8'hA5, 0, 8'hA5, 0, 0);
        add(0, 8'h00, 0, 8'hA5, 0, 0);
        add(0, 8'h00, 0, 8'hA5, 0, 0);
        add(0, 8'h00, 1, 8'hA5, 0, 1);
        add(0, 8'h00, 1, 8'hA5, 0, 0);
        // 0xFF offered while busy with 0xA5
        add(1, 8'hA5, 0, 8'hA5, 1, 0);
        add(1, 8'hFF, 0, 8'hA5, 1, 0);
        add(1, 8'hFF, 0, 8'hA5, 1, 0);
        add(1, 8'hFF, 1, 8'hA5, 1, 1);
        add(1, 8'hFF, 0, 8'hFF, 0, 0);
        add(0, 8'h00, 0, 8'hFF, 0, 0);
        add(0, 8'h00, 0, 8'hFF, 0, 0);
        add(0, 8'h00, 1, 8'hFF, 0, 1);
        add(0, 8'h00, 1, 8'hFF, 0, 0);

        // reset state
        #12;
        check("rst_ready", ow_ready, 1);
        check("rst_xdata", owv_xdata, 0);
        check("rst_xreq", ow_xreq, 0);
        check("rst_done", ow_done, 0);
        check("rst_timeout", ow_timeout, 0);
        tick();
        iw_rst = 1'b0;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            iw_valid = tbl[i].v;
            iwv_data = tbl[i].d;
            tick();
            check($sformatf("v%0d_ready", i), ow_ready, tbl[i].r);
            check($sformatf("v%0d_xdata", i), owv_xdata, tbl[i].x);
            check($sformatf("v%0d_xreq", i), ow_xreq, tbl[i].q);
            check($sformatf("v%0d_done", i), ow_done, tbl[i].dn);
            check($sformatf("v%0d_timeout", i), ow_timeout, 0);
        end

        // delayed ack: far side toggles 20 cycles after the request
        loop = 1'b0;
        xack_man = 1'b0;
        iw_valid = 1'b1;
        iwv_data = 8'h5A;
        tick();
        iw_valid = 1'b0;
        check("dly_xreq", ow_xreq, 1);
        check("dly_xdata", owv_xdata, 8'h5A);
        for (int k = 1; k <= 22; k++) begin
            tick();
            check($sformatf("dly_ready_e%0d", k), ow_ready, 0);
            check($sformatf("dly_done_e%0d", k), ow_done, 0);
            if (k == 15) check("to_before", ow_timeout, 0);
            if (k == 16) check("to_rise", ow_timeout, TO_EXP);
            if (k == 20) xack_man = 1'b1;
        end
        tick();
        check("dly_ready_e23", ow_ready, 1);
        check("dly_done_e23", ow_done, 1);
        check("to_held_done", ow_timeout, TO_EXP);
        tick();
        check("dly_done_e24", ow_done, 0);
        check("to_held_after", ow_timeout, TO_EXP);

        // async reset while waiting
        iw_valid = 1'b1;
        iwv_data = 8'hC3;
        tick();
        iw_valid = 1'b0;
        tick();
        check("mid_ready", ow_ready, 0);
        check("mid_xdata", owv_xdata, 8'hC3);
        check("mid_xreq", ow_xreq, 0);
        #2;
        iw_rst = 1'b1;
        #1;
        check("arst_ready", ow_ready, 1);
        check("arst_xdata", owv_xdata, 0);
        check("arst_xreq", ow_xreq, 0);
        check("arst_done", ow_done, 0);
        check("arst_timeout", ow_timeout, 0);
        tick();
        iw_rst = 1'b0;
        tick();
        check("post_ready", ow_ready, 1);
        check("post_done", ow_done, 0);
        check("post_xreq", ow_xreq, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
